// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared branch predictor types and PHT counter encodings
package bp_pkg;

   localparam int unsigned PHT_INDEX_WIDTH = 10;

   // 2-bit saturating counter states, shared with the PHT array
   localparam logic [1:0] STRONGLY_NOT_TAKEN = 2'b00;
   localparam logic [1:0] WEAKLY_NOT_TAKEN   = 2'b01;
   localparam logic [1:0] WEAKLY_TAKEN       = 2'b10;
   localparam logic [1:0] STRONGLY_TAKEN     = 2'b11;

   typedef struct packed {
      logic [PHT_INDEX_WIDTH-1:0] index;
      logic                       taken;
   } pht_upd_t;

   // Saturating counter step applied by the PHT when an update strobe arrives
   function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
      logic [1:0] nxt;
      nxt = ctr;
      if (taken && ctr != STRONGLY_TAKEN) begin
         nxt = ctr + 2'd1;
      end else if (!taken && ctr != STRONGLY_NOT_TAKEN) begin
         nxt = ctr - 2'd1;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/bp_upd_fifo.sv
// rtl/bp_upd_fifo.sv - synchronous queue of pending PHT updates
module bp_upd_fifo
   import bp_pkg::*;
#(
   parameter int unsigned INDEX_WIDTH = PHT_INDEX_WIDTH,
   parameter int unsigned DEPTH       = 4
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         push_i,
   input  logic [INDEX_WIDTH-1:0]       push_index_i,
   input  logic                         push_taken_i,
   input  logic                         pop_i,
   output logic [INDEX_WIDTH-1:0]       head_index_o,
   output logic                         head_taken_o,
   output logic                         full_o,
   output logic                         empty_o,
   output logic [$clog2(DEPTH):0]       count_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   // Same layout as pht_upd_t, sized by this instance's index width
   typedef struct packed {
      logic [INDEX_WIDTH-1:0] index;
      logic                   taken;
   } upd_t;

   upd_t             mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;
   upd_t             head;

   assign full_o  = (count == CNT_W'(DEPTH));
   assign empty_o = (count == '0);
   assign count_o = count;

   // Overflowing pushes and underflowing pops are ignored
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   // Head reads as zero when nothing is queued
   assign head         = empty_o ? '0 : mem[rd_ptr];
   assign head_index_o = head.index;
   assign head_taken_o = head.taken;

   // Storage write; contents need no reset since the head is masked when empty
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem[wr_ptr] <= '{index: push_index_i, taken: push_taken_i};
      end
   end

   // Pointers wrap naturally (power-of-two depth); count tracks occupancy
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/pht_update_ctrl.sv
// rtl/pht_update_ctrl.sv - PHT index hash, GHR tracking and update sequencing
module pht_update_ctrl
   import bp_pkg::*;
#(
   parameter int unsigned PC_WIDTH    = 32,
   parameter int unsigned INDEX_WIDTH = PHT_INDEX_WIDTH,
   parameter int unsigned GHR_WIDTH   = 10,
   parameter int unsigned QUEUE_DEPTH = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic [PC_WIDTH-1:0]    fetch_pc_i,
   input  logic                   fetch_br_i,
   input  logic                   fetch_pred_i,
   output logic [INDEX_WIDTH-1:0] rd_index_o,
   input  logic                   res_valid_i,
   output logic                   res_ready_o,
   input  logic [INDEX_WIDTH-1:0] res_index_i,
   input  logic                   res_taken_i,
   input  logic                   res_mispred_i,
   input  logic                   flush_i,
   input  logic                   pht_ready_i,
   output logic                   update_en_o,
   output logic [INDEX_WIDTH-1:0] update_index_o,
   output logic                   br_taken_o,
   output logic [GHR_WIDTH-1:0]   spec_ghr_o
);

   logic [GHR_WIDTH-1:0]        spec_ghr;
   logic [GHR_WIDTH-1:0]        spec_ghr_next;
   logic [GHR_WIDTH-1:0]        commit_ghr;
   logic [GHR_WIDTH-1:0]        commit_ghr_next;
   logic                        accepted;
   logic                        recover;
   logic                        fifo_full;
   logic                        fifo_empty;
   logic [$clog2(QUEUE_DEPTH):0] fifo_count_unused;
   logic                        pc_unused;

   // Word-aligned PC bits hashed with the zero-extended speculative history
   assign rd_index_o = fetch_pc_i[INDEX_WIDTH+1:2] ^ INDEX_WIDTH'(spec_ghr);
   assign pc_unused  = ^{fetch_pc_i[PC_WIDTH-1:INDEX_WIDTH+2], fetch_pc_i[1:0]};

   // Ready is a decode of the registered occupancy; no pass-through when full
   assign res_ready_o = !fifo_full;
   assign accepted    = res_valid_i && res_ready_o;
   assign update_en_o = !fifo_empty && pht_ready_i;
   assign spec_ghr_o  = spec_ghr;

   bp_upd_fifo #(
      .INDEX_WIDTH (INDEX_WIDTH),
      .DEPTH       (QUEUE_DEPTH)
   ) u_upd_fifo (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .push_i       (accepted),
      .push_index_i (res_index_i),
      .push_taken_i (res_taken_i),
      .pop_i        (update_en_o),
      .head_index_o (update_index_o),
      .head_taken_o (br_taken_o),
      .full_o       (fifo_full),
      .empty_o      (fifo_empty),
      .count_o      (fifo_count_unused)
   );

   // Next-state for both histories; the shift form also covers a 1-bit history
   always_comb begin
      commit_ghr_next = commit_ghr;
      spec_ghr_next   = spec_ghr;
      recover         = (accepted && res_mispred_i) || flush_i;
      if (accepted) begin
         commit_ghr_next = (commit_ghr << 1) | GHR_WIDTH'(res_taken_i);
      end
      if (recover) begin
         // Recovery wins; a fetch shift in the same cycle is wrong-path and dropped
         spec_ghr_next = commit_ghr_next;
      end else if (fetch_br_i) begin
         spec_ghr_next = (spec_ghr << 1) | GHR_WIDTH'(fetch_pred_i);
      end
   end

   // History registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         spec_ghr   <= '0;
         commit_ghr <= '0;
      end else begin
         spec_ghr   <= spec_ghr_next;
         commit_ghr <= commit_ghr_next;
      end
   end

endmodule
